// File: rtl/game_pkg.sv
// Shared game datapath types: direction and edge-mode encodings, screen size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic {
      MODE_WRAP   = 1'b0,
      MODE_BOUNCE = 1'b1
   } mode_e;

   // Visible screen size in pixels.
   localparam int H_MAX = 640;
   localparam int V_MAX = 480;

endpackage

// File: rtl/obj_motion_engine_if.sv
// Control/config/player inputs and object/collision outputs of the motion engine.
// Latency: n/a (wiring only).
// Backpressure: none; every input is sampled each cycle.
// Ports: slave = engine side, master = driver (player logic / video controller / bench).
interface obj_motion_engine_if #(
   parameter int N_OBJ   = 8,
   parameter int COORD_W = 10
);
   logic                       tick;
   logic                       freeze;
   logic                       mode;
   logic                       cfg_wr;
   logic [3:0]                 cfg_idx;
   logic [COORD_W-1:0]         cfg_h;
   logic [COORD_W-1:0]         cfg_v;
   logic [1:0]                 cfg_dir;
   logic [COORD_W-1:0]         ply_h;
   logic [COORD_W-1:0]         ply_v;
   logic                       hit_clr;
   logic [N_OBJ*COORD_W-1:0]   obj_h;
   logic [N_OBJ*COORD_W-1:0]   obj_v;
   logic [N_OBJ*2-1:0]         obj_dir;
   logic [N_OBJ-1:0]           hit;
   logic                       blk_up;
   logic                       blk_down;
   logic                       blk_left;
   logic                       blk_right;
   logic [15:0]                hit_cnt;

   modport slave (
      input  tick, freeze, mode, cfg_wr, cfg_idx, cfg_h, cfg_v, cfg_dir, ply_h, ply_v, hit_clr,
      output obj_h, obj_v, obj_dir, hit, blk_up, blk_down, blk_left, blk_right, hit_cnt
   );

   modport master (
      output tick, freeze, mode, cfg_wr, cfg_idx, cfg_h, cfg_v, cfg_dir, ply_h, ply_v, hit_clr,
      input  obj_h, obj_v, obj_dir, hit, blk_up, blk_down, blk_left, blk_right, hit_cnt
   );
endinterface

// File: rtl/obj_motion_cell.sv
// One object's h/v/dir registers with config load, step move and wrap/bounce edge handling.
// Latency: load or move visible one cycle after the qualifying cycle.
// Backpressure: none; a load always wins over a move in the same cycle.
// Ports: mv_en move strobe, mode wrap/bounce, ld/ld_h/ld_v/ld_dir load, h/v/dir current state.
module obj_motion_cell
   import game_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int OBJ_W   = 32,
   parameter int OBJ_H   = 16,
   parameter int STEP    = 2,
   parameter int RST_H   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mv_en,
   input  logic               mode,
   input  logic               ld,
   input  logic [COORD_W-1:0] ld_h,
   input  logic [COORD_W-1:0] ld_v,
   input  logic [1:0]         ld_dir,
   output logic [COORD_W-1:0] h,
   output logic [COORD_W-1:0] v,
   output logic [1:0]         dir
);
   localparam int W1 = COORD_W + 1;
   // Edge compares use one extra bit so h+STEP never overflows.
   localparam logic [W1-1:0]      H_LIM  = W1'(H_MAX - OBJ_W);
   localparam logic [W1-1:0]      V_LIM  = W1'(V_MAX - OBJ_H);
   localparam logic [W1-1:0]      STEP_X = W1'(STEP);
   localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

   logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
   dir_e               dir_q, dir_d;
   logic [W1-1:0]      h_x, v_x;

   always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      dir_d = dir_q;
      h_x   = {1'b0, h_q};
      v_x   = {1'b0, v_q};
      if (ld) begin
         h_d   = ({1'b0, ld_h} > H_LIM) ? H_LIM[COORD_W-1:0] : ld_h;
         v_d   = ({1'b0, ld_v} > V_LIM) ? V_LIM[COORD_W-1:0] : ld_v;
         dir_d = dir_e'(ld_dir);
      end else if (mv_en) begin
         // At an edge a bounce only reverses direction; position holds for that tick.
         case (dir_q)
            DIR_RIGHT: begin
               if (h_x + STEP_X > H_LIM) begin
                  if (mode == MODE_BOUNCE) dir_d = DIR_LEFT;
                  else                     h_d   = '0;
               end else h_d = h_q + STEP_C;
            end
            DIR_LEFT: begin
               if (h_x < STEP_X) begin
                  if (mode == MODE_BOUNCE) dir_d = DIR_RIGHT;
                  else                     h_d   = H_LIM[COORD_W-1:0];
               end else h_d = h_q - STEP_C;
            end
            DIR_DOWN: begin
               if (v_x + STEP_X > V_LIM) begin
                  if (mode == MODE_BOUNCE) dir_d = DIR_UP;
                  else                     v_d   = '0;
               end else v_d = v_q + STEP_C;
            end
            default: begin
               if (v_x < STEP_X) begin
                  if (mode == MODE_BOUNCE) dir_d = DIR_DOWN;
                  else                     v_d   = V_LIM[COORD_W-1:0];
               end else v_d = v_q - STEP_C;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q   <= COORD_W'(RST_H);
         v_q   <= '0;
         dir_q <= DIR_RIGHT;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         dir_q <= dir_d;
      end
   end

   assign h   = h_q;
   assign v   = v_q;
   assign dir = dir_q;
endmodule

// File: rtl/obj_motion_engine.sv
// N-object motion engine: per-object movers, player overlap flags, move-block flags, hit counter.
// Latency: hit/blk_*/hit_cnt registered, one cycle after the object/player state they test.
// Backpressure: none; tick, cfg and player inputs are consumed every cycle.
// Ports: clk, rst_n (async active-low), bus = obj_motion_engine_if slave.
module obj_motion_engine
   import game_pkg::*;
#(
   parameter int N_OBJ   = 8,
   parameter int COORD_W = 10,
   parameter int OBJ_W   = 32,
   parameter int OBJ_H   = 16,
   parameter int PLY_W   = 16,
   parameter int PLY_H   = 16,
   parameter int STEP    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   obj_motion_engine_if.slave bus
);
   localparam int W1 = COORD_W + 1;
   localparam logic [W1-1:0] STEP_X = W1'(STEP);
   localparam logic [W1-1:0] PH_LIM = W1'(H_MAX - PLY_W);
   localparam logic [W1-1:0] PV_LIM = W1'(V_MAX - PLY_H);

   logic [COORD_W-1:0] h_w   [N_OBJ];
   logic [COORD_W-1:0] v_w   [N_OBJ];
   logic [1:0]         dir_w [N_OBJ];
   logic               mv_en;

   assign mv_en = bus.tick & ~bus.freeze;

   for (genvar g = 0; g < N_OBJ; g++) begin : g_cell
      // cfg_idx values >= N_OBJ match no cell, so those writes fall away.
      obj_motion_cell #(
         .COORD_W(COORD_W), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .STEP(STEP),
         .RST_H(g * (H_MAX / N_OBJ))
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .mv_en (mv_en),
         .mode  (bus.mode),
         .ld    (bus.cfg_wr && (bus.cfg_idx == 4'(g))),
         .ld_h  (bus.cfg_h),
         .ld_v  (bus.cfg_v),
         .ld_dir(bus.cfg_dir),
         .h     (h_w[g]),
         .v     (v_w[g]),
         .dir   (dir_w[g])
      );
   end

   // Strict rectangle overlap of a player-sized box against an object-sized box.
   function automatic logic ovl(input logic [W1-1:0] ph, input logic [W1-1:0] pv,
                                input logic [W1-1:0] oh, input logic [W1-1:0] ov);
      return (ph < oh + W1'(OBJ_W)) && (oh < ph + W1'(PLY_W)) &&
             (pv < ov + W1'(OBJ_H)) && (ov < pv + W1'(PLY_H));
   endfunction

   logic [N_OBJ-1:0] hit_q, hit_d;
   logic             blk_up_q, blk_up_d, blk_down_q, blk_down_d;
   logic             blk_left_q, blk_left_d, blk_right_q, blk_right_d;
   logic [15:0]      hit_cnt_q, hit_cnt_d;
   logic [W1-1:0]    ph, pv, ph_l, ph_r, pv_u, pv_d, oh, ov;
   logic             rise;

   always_comb begin
      ph   = {1'b0, bus.ply_h};
      pv   = {1'b0, bus.ply_v};
      // Shifted player box, clamped to the screen.
      ph_l = (ph < STEP_X) ? '0 : ph - STEP_X;
      pv_u = (pv < STEP_X) ? '0 : pv - STEP_X;
      ph_r = (ph + STEP_X > PH_LIM) ? PH_LIM : ph + STEP_X;
      pv_d = (pv + STEP_X > PV_LIM) ? PV_LIM : pv + STEP_X;
      blk_up_d    = (pv < STEP_X);
      blk_left_d  = (ph < STEP_X);
      blk_down_d  = (pv + STEP_X > PV_LIM);
      blk_right_d = (ph + STEP_X > PH_LIM);
      hit_d = '0;
      oh    = '0;
      ov    = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         oh = {1'b0, h_w[i]};
         ov = {1'b0, v_w[i]};
         hit_d[i]    = ovl(ph, pv, oh, ov);
         blk_up_d    = blk_up_d    | ovl(ph, pv_u, oh, ov);
         blk_down_d  = blk_down_d  | ovl(ph, pv_d, oh, ov);
         blk_left_d  = blk_left_d  | ovl(ph_l, pv, oh, ov);
         blk_right_d = blk_right_d | ovl(ph_r, pv, oh, ov);
      end
      // Count on the rising edge of "any hit", lined up with the hit register update.
      rise      = (|hit_d) & ~(|hit_q);
      hit_cnt_d = hit_cnt_q;
      if (bus.hit_clr)                          hit_cnt_d = '0;
      else if (rise && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q       <= '0;
         blk_up_q    <= 1'b0;
         blk_down_q  <= 1'b0;
         blk_left_q  <= 1'b0;
         blk_right_q <= 1'b0;
         hit_cnt_q   <= '0;
      end else begin
         hit_q       <= hit_d;
         blk_up_q    <= blk_up_d;
         blk_down_q  <= blk_down_d;
         blk_left_q  <= blk_left_d;
         blk_right_q <= blk_right_d;
         hit_cnt_q   <= hit_cnt_d;
      end
   end

   logic [N_OBJ*COORD_W-1:0] obj_h_pk, obj_v_pk;
   logic [N_OBJ*2-1:0]       obj_dir_pk;

   always_comb begin
      obj_h_pk   = '0;
      obj_v_pk   = '0;
      obj_dir_pk = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         obj_h_pk[i*COORD_W +: COORD_W] = h_w[i];
         obj_v_pk[i*COORD_W +: COORD_W] = v_w[i];
         obj_dir_pk[i*2 +: 2]           = dir_w[i];
      end
   end

   assign bus.obj_h     = obj_h_pk;
   assign bus.obj_v     = obj_v_pk;
   assign bus.obj_dir   = obj_dir_pk;
   assign bus.hit       = hit_q;
   assign bus.blk_up    = blk_up_q;
   assign bus.blk_down  = blk_down_q;
   assign bus.blk_left  = blk_left_q;
   assign bus.blk_right = blk_right_q;
   assign bus.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_obj_motion_engine.sv
// Self-checking bench for obj_motion_engine: directed corner sequences, a collision vector table
// and a randomized run against a rule-level reference model.
// Backpressure: none exercised (engine has none).
module tb_obj_motion_engine;
   localparam int N = 8, CW = 10, OW = 32, OH = 16, PW = 16, PH = 16, ST = 2;
   localparam int HM = 640, VM = 480;
   localparam int HL = HM - OW, VL = VM - OH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obj_motion_engine_if #(.N_OBJ(N), .COORD_W(CW)) bus ();

   obj_motion_engine #(
      .N_OBJ(N), .COORD_W(CW), .OBJ_W(OW), .OBJ_H(OH),
      .PLY_W(PW), .PLY_H(PH), .STEP(ST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int mh [N];
   int mv [N];
   int md [N];
   int mcnt;
   bit mprev;
   logic [N-1:0] ehit;
   bit eu, ed, el, er;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit ovl(int ph, int pv, int oh, int ov);
      return (ph < oh + OW) && (oh < ph + PW) && (pv < ov + OH) && (ov < pv + PH);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mh[i] = i * (HM / N);
         mv[i] = 0;
         md[i] = 3;
      end
      mcnt = 0; mprev = 0; ehit = '0;
      eu = 0; ed = 0; el = 0; er = 0;
   endtask

   task automatic chk_model();
      logic [N*CW-1:0] xh, xv;
      logic [N*2-1:0]  xd;
      for (int i = 0; i < N; i++) begin
         xh[i*CW +: CW] = CW'(mh[i]);
         xv[i*CW +: CW] = CW'(mv[i]);
         xd[i*2 +: 2]   = 2'(md[i]);
      end
      chk("obj_h", bus.obj_h, xh);
      chk("obj_v", bus.obj_v, xv);
      chk("obj_dir", bus.obj_dir, xd);
      chk("hit", bus.hit, ehit);
      chk("blk", {bus.blk_up, bus.blk_down, bus.blk_left, bus.blk_right}, {eu, ed, el, er});
      chk("hit_cnt", bus.hit_cnt, mcnt);
   endtask

   // One clock: predict from model state + current inputs, clock, then compare.
   task automatic step();
      int ph, pv, su, sd, sl, sr, h, v, d;
      logic [N-1:0] nh;
      bit bu, bd, bl, br;
      ph = int'(bus.ply_h); pv = int'(bus.ply_v);
      su = (pv < ST) ? 0 : pv - ST;
      sl = (ph < ST) ? 0 : ph - ST;
      sd = (pv + ST > VM - PH) ? VM - PH : pv + ST;
      sr = (ph + ST > HM - PW) ? HM - PW : ph + ST;
      bu = pv < ST; bl = ph < ST; bd = pv + ST > VM - PH; br = ph + ST > HM - PW;
      for (int i = 0; i < N; i++) begin
         nh[i] = ovl(ph, pv, mh[i], mv[i]);
         bu |= ovl(ph, su, mh[i], mv[i]);
         bd |= ovl(ph, sd, mh[i], mv[i]);
         bl |= ovl(sl, pv, mh[i], mv[i]);
         br |= ovl(sr, pv, mh[i], mv[i]);
      end
      if (bus.hit_clr) mcnt = 0;
      else if ((nh != 0) && !mprev && mcnt < 65535) mcnt++;
      mprev = (nh != 0);
      ehit = nh; eu = bu; ed = bd; el = bl; er = br;
      for (int i = 0; i < N; i++) begin
         h = mh[i]; v = mv[i]; d = md[i];
         if (bus.cfg_wr && int'(bus.cfg_idx) == i) begin
            h = (int'(bus.cfg_h) > HL) ? HL : int'(bus.cfg_h);
            v = (int'(bus.cfg_v) > VL) ? VL : int'(bus.cfg_v);
            d = int'(bus.cfg_dir);
         end else if (bus.tick && !bus.freeze) begin
            case (d)
               3: if (h + ST > HL) begin if (bus.mode) d = 2; else h = 0;  end else h += ST;
               2: if (h < ST)      begin if (bus.mode) d = 3; else h = HL; end else h -= ST;
               1: if (v + ST > VL) begin if (bus.mode) d = 0; else v = 0;  end else v += ST;
               default: if (v < ST) begin if (bus.mode) d = 1; else v = VL; end else v -= ST;
            endcase
         end
         mh[i] = h; mv[i] = v; md[i] = d;
      end
      @(posedge clk);
      #1;
      chk_model();
   endtask

   task automatic cfg(input int idx, input int h, input int v, input int d);
      bus.cfg_wr = 1'b1; bus.cfg_idx = 4'(idx);
      bus.cfg_h = CW'(h); bus.cfg_v = CW'(v); bus.cfg_dir = 2'(d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      rst_n = 1'b1;
      #1;
   endtask

   typedef struct {
      int oh, ov, ph, pv;
      logic [4:0] exp;   // {hit0, up, down, left, right}
      int ecnt;
   } vec_t;
   vec_t tbl [11];

   logic [N*CW-1:0] rst_h_exp;

   initial begin
      tbl[0]  = '{100, 100, 120, 110, 5'b11111, 1};
      tbl[1]  = '{100, 100, 132, 110, 5'b00010, 1};
      tbl[2]  = '{100, 100,  84, 110, 5'b00001, 1};
      tbl[3]  = '{100, 100, 110, 116, 5'b01000, 1};
      tbl[4]  = '{100, 100, 110,  84, 5'b00100, 1};
      tbl[5]  = '{300, 300,   0, 200, 5'b00010, 1};
      tbl[6]  = '{300, 300, 624, 464, 5'b00101, 1};
      tbl[7]  = '{300, 300, 623, 300, 5'b00001, 1};
      tbl[8]  = '{300, 300,   1,   1, 5'b01010, 1};
      tbl[9]  = '{300, 300,   2,   2, 5'b00000, 1};
      tbl[10] = '{100, 100, 131, 115, 5'b11010, 2};
      for (int i = 0; i < N; i++) rst_h_exp[i*CW +: CW] = CW'(i * 80);

      bus.tick = 0; bus.freeze = 0; bus.mode = 0; bus.cfg_wr = 0; bus.cfg_idx = 0;
      bus.cfg_h = 0; bus.cfg_v = 0; bus.cfg_dir = 0; bus.hit_clr = 0;
      bus.ply_h = CW'(300); bus.ply_v = CW'(400);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      // Reset state.
      chk("rst_obj_h", bus.obj_h, rst_h_exp);
      chk("rst_obj_v", bus.obj_v, 0);
      chk("rst_obj_dir", bus.obj_dir, 16'hFFFF);
      chk("rst_hit", bus.hit, 0);
      chk("rst_hit_cnt", bus.hit_cnt, 0);
      rst_n = 1'b1;
      step();

      // Wrap at right edge.
      cfg(0, 606, 50, 3); step(); bus.cfg_wr = 0;
      bus.tick = 1; step();
      chk("wrap_h608", bus.obj_h[CW-1:0], 608);
      step();
      chk("wrap_h0", bus.obj_h[CW-1:0], 0);
      bus.tick = 0;

      // Bounce at left edge.
      bus.mode = 1; cfg(0, 1, 50, 2); step(); bus.cfg_wr = 0;
      bus.tick = 1; step();
      chk("bounce_dir", bus.obj_dir[1:0], 3);
      chk("bounce_h1", bus.obj_h[CW-1:0], 1);
      step();
      chk("bounce_h3", bus.obj_h[CW-1:0], 3);
      bus.tick = 0; bus.mode = 0;

      // Load beats tick; out-of-range index ignored.
      bus.tick = 1; cfg(3, 200, 300, 1); step();
      chk("ld_h3", bus.obj_h[3*CW +: CW], 200);
      chk("ld_v3", bus.obj_v[3*CW +: CW], 300);
      chk("ld_dir3", bus.obj_dir[7:6], 1);
      bus.tick = 0; cfg(12, 5, 5, 0); step(); bus.cfg_wr = 0;
      chk("idx12_h3", bus.obj_h[3*CW +: CW], 200);
      chk("idx12_v3", bus.obj_v[3*CW +: CW], 300);

      // Collision / block vector table from a known reset layout.
      do_reset();
      for (int k = 0; k < 11; k++) begin
         bus.ply_h = CW'(400); bus.ply_v = CW'(400);
         cfg(0, tbl[k].oh, tbl[k].ov, 3); step(); bus.cfg_wr = 0;
         bus.ply_h = CW'(tbl[k].ph); bus.ply_v = CW'(tbl[k].pv);
         step();
         chk($sformatf("tbl%0d_hit", k), bus.hit, {7'b0, tbl[k].exp[4]});
         chk($sformatf("tbl%0d_blk", k),
             {bus.blk_up, bus.blk_down, bus.blk_left, bus.blk_right}, tbl[k].exp[3:0]);
         chk($sformatf("tbl%0d_cnt", k), bus.hit_cnt, tbl[k].ecnt);
      end

      // Saturation: preset the counter near the top, then keep producing rises.
      bus.ply_h = CW'(400); bus.ply_v = CW'(400); step();
      force dut.hit_cnt_q = 16'hFFFD;
      #1;
      release dut.hit_cnt_q;
      mcnt = 16'hFFFD;
      for (int k = 0; k < 4; k++) begin
         bus.ply_h = CW'(120); bus.ply_v = CW'(110); step();
         bus.ply_h = CW'(400); bus.ply_v = CW'(400); step();
      end
      chk("sat_ffff", bus.hit_cnt, 16'hFFFF);
      bus.ply_h = CW'(120); bus.ply_v = CW'(110); bus.hit_clr = 1; step();
      chk("clr_wins", bus.hit_cnt, 0);
      bus.hit_clr = 0;
      bus.ply_h = CW'(400); bus.ply_v = CW'(400); step();
      bus.ply_h = CW'(120); bus.ply_v = CW'(110); step();
      chk("cnt_after_clr", bus.hit_cnt, 1);

      // Randomized run with a mid-run asynchronous reset.
      for (int n = 0; n < 3000; n++) begin
         int k, t;
         bus.tick    = ($urandom_range(0, 9) < 4);
         bus.freeze  = ($urandom_range(0, 4) == 0);
         bus.mode    = $urandom_range(0, 1);
         bus.hit_clr = ($urandom_range(0, 49) == 0);
         bus.cfg_wr  = ($urandom_range(0, 9) == 0);
         bus.cfg_idx = 4'($urandom_range(0, 15));
         bus.cfg_h   = CW'($urandom_range(0, 1023));
         bus.cfg_v   = CW'($urandom_range(0, 1023));
         bus.cfg_dir = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            bus.ply_h = CW'($urandom_range(0, 639));
            bus.ply_v = CW'($urandom_range(0, 479));
         end else begin
            k = $urandom_range(0, N - 1);
            t = mh[k] + int'($urandom_range(0, 60)) - 30;
            bus.ply_h = CW'((t < 0) ? 0 : t);
            t = mv[k] + int'($urandom_range(0, 40)) - 20;
            bus.ply_v = CW'((t < 0) ? 0 : t);
         end
         step();
         if (n == 1500) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_rst_h", bus.obj_h, rst_h_exp);
            chk("async_rst_v", bus.obj_v, 0);
            chk("async_rst_cnt", bus.hit_cnt, 0);
            chk("async_rst_hit", bus.hit, 0);
            model_reset();
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
